// File: rtl/mem_arb_pkg.sv
// Purpose : shared constants and request record for the two-port memory request arbiter.
// Latency : n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Number of requesting ports; the arbiter and its round-robin are built for two.
    localparam int NUM_PORTS = 2;

    // Default configuration of the arbiter.
    localparam int DEF_ADDR_WIDTH      = 32;
    localparam int DEF_LINE_WIDTH      = 32;
    localparam int DEF_CREG_ID_BITS    = 4;
    localparam int DEF_MAX_OUTSTANDING = 4;

    // Position of the port-select bit inside a memory-side ID (its MSB).
    localparam int PORT_BIT = DEF_CREG_ID_BITS - 1;

    // Outstanding-read counters hold 0..7.
    localparam int CNT_WIDTH = 3;

    // Request record at the default widths: address, write data, direction, port-side ID.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic [DEF_LINE_WIDTH-1:0]   data;
        logic                        rw;
        logic [DEF_CREG_ID_BITS-2:0] id;
    } mem_req_t;

    // Port-select bit position for an arbitrary memory-side ID width.
    function automatic int port_bit_pos(input int id_bits);
        return id_bits - 1;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Purpose : two-way round-robin grant; the port not granted last wins a tie.
// Latency : grant is combinational from req; the last-grant register updates on the clock edge.
// Backpressure: none; the caller masks req when it cannot accept a grant.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req[1:0]       per-port request (already qualified by the caller)
//   advance        a grant was taken this cycle; record who got it
//   gnt[1:0]       one-hot (or zero) grant
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 means port 1 was granted last, so port 0 has priority on the next tie.
    // Reset to 1 so port 0 is served first.
    logic r_last;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (advance) begin
            r_last <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Purpose : merges two request ports onto one memory-controller port through a single
//           output register, limits reads in flight per port and routes read responses back.
// Latency : one cycle request-to-memory; zero-cycle (combinational) response routing.
// Backpressure: mem_stall_in freezes the output register; a port sees pN_stall_out=1 in any
//           cycle it is not granted (stage busy, lost arbitration, or read credit exhausted).
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   pN_addr/data/rw/valid/id_in      request from port N (rw=1 write)
//   pN_stall_out                     request not accepted this cycle
//   pN_data/id/ready_out             read response for port N
//   mem_addr/data/rw/valid/id_out    registered request to memory (id MSB = port)
//   mem_stall/data/id/ready_in       memory controller stall and read response
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH      = DEF_LINE_WIDTH,
    parameter int CREG_ID_BITS    = DEF_CREG_ID_BITS,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
)
(
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   p0_addr_in,
    input  logic [LINE_WIDTH-1:0]   p0_data_in,
    input  logic                    p0_rw_in,
    input  logic                    p0_valid_in,
    input  logic [CREG_ID_BITS-2:0] p0_id_in,
    output logic                    p0_stall_out,
    output logic [LINE_WIDTH-1:0]   p0_data_out,
    output logic [CREG_ID_BITS-2:0] p0_id_out,
    output logic                    p0_ready_out,

    input  logic [ADDR_WIDTH-1:0]   p1_addr_in,
    input  logic [LINE_WIDTH-1:0]   p1_data_in,
    input  logic                    p1_rw_in,
    input  logic                    p1_valid_in,
    input  logic [CREG_ID_BITS-2:0] p1_id_in,
    output logic                    p1_stall_out,
    output logic [LINE_WIDTH-1:0]   p1_data_out,
    output logic [CREG_ID_BITS-2:0] p1_id_out,
    output logic                    p1_ready_out,

    output logic [ADDR_WIDTH-1:0]   mem_addr_out,
    output logic [LINE_WIDTH-1:0]   mem_data_out,
    output logic                    mem_rw_out,
    output logic                    mem_valid_out,
    output logic [CREG_ID_BITS-1:0] mem_id_out,

    input  logic                    mem_stall_in,
    input  logic [LINE_WIDTH-1:0]   mem_data_in,
    input  logic [CREG_ID_BITS-1:0] mem_id_in,
    input  logic                    mem_ready_in
);

    localparam int                   P_BIT   = port_bit_pos(CREG_ID_BITS);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    // Request record at this instance's widths.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0]   data;
        logic                    rw;
        logic [CREG_ID_BITS-2:0] id;
    } req_t;

    req_t                   w_req [NUM_PORTS];
    req_t                   w_sel;
    logic [NUM_PORTS-1:0]   w_valid;
    logic [NUM_PORTS-1:0]   w_elig;
    logic [NUM_PORTS-1:0]   w_gnt;
    logic [NUM_PORTS-1:0]   w_inc;
    logic [NUM_PORTS-1:0]   w_rsp_hit;
    logic                   w_stage_free;

    logic [CNT_WIDTH-1:0]    r_cnt [NUM_PORTS];
    logic                    r_valid;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_data;
    logic                    r_rw;
    logic [CREG_ID_BITS-1:0] r_id;

    assign w_req[0] = req_t'{p0_addr_in, p0_data_in, p0_rw_in, p0_id_in};
    assign w_req[1] = req_t'{p1_addr_in, p1_data_in, p1_rw_in, p1_id_in};
    assign w_valid  = {p1_valid_in, p0_valid_in};

    // The output register can take a new request when it is empty or being drained.
    assign w_stage_free = ~r_valid | ~mem_stall_in;

    for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
        // Eligibility uses the registered count, so a response arriving in the same
        // cycle does not free a credit until the next cycle.
        assign w_elig[n]    = w_valid[n] & (w_req[n].rw | (r_cnt[n] < MAX_CNT));
        assign w_inc[n]     = w_gnt[n] & ~w_req[n].rw;
        assign w_rsp_hit[n] = mem_ready_in & (mem_id_in[P_BIT] == 1'(n));

        // A response for a port with nothing in flight is an illegal stimulus.
        a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
            !(w_rsp_hit[n] && (r_cnt[n] == '0)));
    end

    mem_arb_rr2 u_rr (
        .clk     (clk),
        .rst     (reset),
        .req     (w_elig & {NUM_PORTS{w_stage_free}}),
        .advance (|w_gnt),
        .gnt     (w_gnt)
    );

    assign w_sel = w_gnt[1] ? w_req[1] : w_req[0];

    // Stall is forced during reset so nothing appears accepted while state is cleared.
    assign p0_stall_out = reset | ~w_gnt[0];
    assign p1_stall_out = reset | ~w_gnt[1];

    // Output register: loads on grant, empties when free with no grant, holds under stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rw    <= 1'b0;
            r_id    <= '0;
        end else if (w_stage_free) begin
            if (|w_gnt) begin
                r_valid <= 1'b1;
                r_addr  <= w_sel.addr;
                r_data  <= w_sel.data;
                r_rw    <= w_sel.rw;
                r_id    <= {w_gnt[1], w_sel.id};
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // Reads in flight per port; an accept and a response together cancel out,
    // and the count never wraps below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_PORTS; n++) begin
                r_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_PORTS; n++) begin
                if (w_inc[n] && !w_rsp_hit[n]) begin
                    r_cnt[n] <= r_cnt[n] + CNT_WIDTH'(1);
                end else if (w_rsp_hit[n] && !w_inc[n] && (r_cnt[n] != '0)) begin
                    r_cnt[n] <= r_cnt[n] - CNT_WIDTH'(1);
                end
            end
        end
    end

    assign mem_valid_out = r_valid;
    assign mem_addr_out  = r_addr;
    assign mem_data_out  = r_data;
    assign mem_rw_out    = r_rw;
    assign mem_id_out    = r_id;

    // Responses are steered by the ID MSB with no added latency.
    assign p0_ready_out = w_rsp_hit[0];
    assign p1_ready_out = w_rsp_hit[1];
    assign p0_id_out    = mem_id_in[CREG_ID_BITS-2:0];
    assign p1_id_out    = mem_id_in[CREG_ID_BITS-2:0];
    assign p0_data_out  = mem_data_in;
    assign p1_data_out  = mem_data_in;

endmodule
